// File: rtl/saladin_pkg.sv
// Shared types for the PLM scheduler return path: grant tags and kernel/consumer sizing helpers.
package saladin_pkg;

  localparam int CID_MAX_W = 8;
  localparam int CNT_W     = 16;

  // Consumer field is sized for the largest supported consumer count; unused MSBs stay zero.
  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [CID_MAX_W-1:0] consumer;
  } grant_tag_t;

  function automatic int cid_width(input int nconsumers);
    return (nconsumers > 1) ? $clog2(nconsumers) : 1;
  endfunction

  function automatic int kernel_id(input int bank, input int port, input int nports);
    return bank * nports + port;
  endfunction

endpackage

// File: rtl/rr_response_router_grant_delay_line.sv
// Per-kernel grant tag delay line; its last stage lines up with the PLM read data.
module grant_delay_line
  import saladin_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  grant_tag_t tag_in,
  output grant_tag_t tag_out
);

  grant_tag_t [DEPTH-1:0] tag_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[DEPTH-1];

endmodule

// File: rtl/rr_response_router.sv
// Return path of the round-robin PLM scheduler: routes each kernel's retiring read data / write ack
// to the consumer that was granted on it, flagging and counting same-consumer collisions.
module rr_response_router
  import saladin_pkg::*;
#(
  parameter  int VALUE_WIDTH = 8,
  parameter  int NCONSUMERS  = 2,
  parameter  int NBANKS      = 1,
  parameter  int NPORTS      = 1,
  parameter  int PLM_LATENCY = 1,
  localparam int NKERNELS    = NBANKS * NPORTS,
  localparam int CID_W       = cid_width(NCONSUMERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NKERNELS-1:0]                   grant_valid,
  input  logic [NKERNELS-1:0]                   grant_wr,
  input  logic [NKERNELS-1:0][CID_W-1:0]        grant_consumer,
  input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]  plm_outputs,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] responses,
  output logic [NCONSUMERS-1:0]                 resp_valid,
  output logic [NCONSUMERS-1:0]                 wr_ack,
  output logic                                  collision_err,
  output logic [CNT_W-1:0]                      collision_count
);

  localparam logic [CNT_W:0] ONE = 1;

  grant_tag_t [NKERNELS-1:0] retire;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      localparam int K = kernel_id(b, p, NPORTS);
      grant_tag_t tag_in;

      assign tag_in = '{valid: grant_valid[K], wr: grant_wr[K],
                        consumer: CID_MAX_W'(grant_consumer[K])};

      grant_delay_line #(.DEPTH(PLM_LATENCY)) u_dl (
        .clk    (clk),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(retire[K])
      );
    end
  end

  logic [NCONSUMERS-1:0]                  hit;
  logic [NCONSUMERS-1:0]                  hit_wr;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] hit_data;
  logic [CNT_W:0]                         drops;
  logic [CNT_W:0]                         cnt_sum;
  logic [CNT_W-1:0]                       cnt_next;

  // Ascending kernel scan: the first claim on a consumer wins, every later one is dropped.
  always_comb begin
    hit      = '0;
    hit_wr   = '0;
    hit_data = '0;
    drops    = '0;
    for (int k = 0; k < NKERNELS; k++) begin
      if (retire[k].valid) begin
        if (retire[k].consumer >= CID_MAX_W'(NCONSUMERS)) drops = drops + ONE;
        for (int c = 0; c < NCONSUMERS; c++) begin
          if (retire[k].consumer == CID_MAX_W'(c)) begin
            if (hit[c]) begin
              drops = drops + ONE;
            end else begin
              hit[c]      = 1'b1;
              hit_wr[c]   = retire[k].wr;
              hit_data[c] = plm_outputs[k];
            end
          end
        end
      end
    end
  end

  assign cnt_sum  = {1'b0, collision_count} + drops;
  assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      responses       <= '0;
      resp_valid      <= '0;
      wr_ack          <= '0;
      collision_err   <= 1'b0;
      collision_count <= '0;
    end else begin
      resp_valid      <= hit & ~hit_wr;
      wr_ack          <= hit & hit_wr;
      collision_count <= cnt_next;
      if (drops != '0) collision_err <= 1'b1;
      for (int c = 0; c < NCONSUMERS; c++)
        if (hit[c] && !hit_wr[c]) responses[c] <= hit_data[c];
    end
  end

endmodule
